// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter with a small TX FIFO in front of the shift register.
// Bytes leave LSB first; frames run back to back while data remains and tx_en is high.
module uart_tx_fifo #(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD_RATE  = 115_200,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_en,
   input  logic       tx_wr_en,
   input  logic [7:0] tx_wr_data,
   output logic       tx_full,
   output logic       tx_empty,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx
);

   localparam int CYCLE = CLK_FREQ / BAUD_RATE;
   localparam int CW    = (CYCLE > 1) ? $clog2(CYCLE) : 1;
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(CYCLE - 1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state, state_n;
   logic [CW-1:0] cycle_cnt, cycle_cnt_n;
   logic [2:0]    bit_cnt, bit_cnt_n;
   logic [7:0]    shift_reg;
   logic          tx_n;
   logic          bit_end;
   logic          pop;
   logic          push;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;

   assign tx_full  = (count == CNT_FULL);
   assign tx_empty = (count == '0);
   assign tx_busy  = (state != IDLE);
   assign bit_end  = (cycle_cnt == CNT_LAST);
   assign tx_done  = (state == STOP) && bit_end;
   // A full FIFO still takes a write on the clock that frees a slot via pop.
   assign push     = tx_wr_en && (!tx_full || pop);

   always_comb begin
      state_n     = state;
      cycle_cnt_n = '0;
      bit_cnt_n   = bit_cnt;
      pop         = 1'b0;
      tx_n        = 1'b1;
      case (state)
         IDLE: begin
            if (tx_en && !tx_empty) begin
               state_n = START;
               pop     = 1'b1;
            end
         end
         START: begin
            cycle_cnt_n = bit_end ? '0 : cycle_cnt + 1'b1;
            if (bit_end) begin
               state_n   = DATA;
               bit_cnt_n = '0;
            end
         end
         DATA: begin
            cycle_cnt_n = bit_end ? '0 : cycle_cnt + 1'b1;
            if (bit_end) begin
               bit_cnt_n = bit_cnt + 1'b1;
               if (bit_cnt == 3'd7) state_n = STOP;
            end
         end
         STOP: begin
            cycle_cnt_n = bit_end ? '0 : cycle_cnt + 1'b1;
            if (bit_end) begin
               if (tx_en && !tx_empty) begin
                  state_n = START;
                  pop     = 1'b1;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
      // Line level is computed one clock ahead so tx comes straight from a flop.
      case (state_n)
         START:   tx_n = 1'b0;
         DATA:    tx_n = shift_reg[bit_cnt_n];
         default: tx_n = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cycle_cnt <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
         tx        <= 1'b1;
      end else begin
         state     <= state_n;
         cycle_cnt <= cycle_cnt_n;
         bit_cnt   <= bit_cnt_n;
         tx        <= tx_n;
         if (pop) shift_reg <= mem[rd_ptr];
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= tx_wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule
